// File: rtl/factorial_engine_pkg.sv
// factorial_engine_pkg: shared types and encodings for the factorial engine.
//   fe_mode_t  : operation select (FACT, DFACT, PERM, RSVD).
//   fe_state_t : engine FSM state (IDLE, CALC, DONE).
package factorial_engine_pkg;

  typedef logic [1:0] fe_mode_t;
  localparam fe_mode_t FACT  = 2'd0;
  localparam fe_mode_t DFACT = 2'd1;
  localparam fe_mode_t PERM  = 2'd2;
  localparam fe_mode_t RSVD  = 2'd3;

  typedef logic [1:0] fe_state_t;
  localparam fe_state_t IDLE = 2'd0;
  localparam fe_state_t CALC = 2'd1;
  localparam fe_state_t DONE = 2'd2;

endpackage

// File: rtl/fe_mul_sat.sv
// fe_mul_sat: combinational OUT_W x IN_W multiply with saturation.
// Ports:
//   acc     in  OUT_W  running product
//   factor  in  IN_W   next term
//   product out OUT_W  acc*factor, or all-ones if it does not fit in OUT_W bits
//   ovf     out 1      high when the full product exceeds OUT_W bits
module fe_mul_sat
  import factorial_engine_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 32
) (
  input  logic [OUT_W-1:0] acc,
  input  logic [IN_W-1:0]  factor,
  output logic [OUT_W-1:0] product,
  output logic             ovf
);

  logic [OUT_W+IN_W-1:0] full;

  always_comb begin
    full    = acc * factor;
    ovf     = |full[OUT_W+IN_W-1:OUT_W];
    product = ovf ? '1 : full[OUT_W-1:0];
  end

endmodule

// File: rtl/factorial_engine.sv
// factorial_engine: sequential product engine computing n!, n!! or P(n,k),
// one multiply per cycle, with sticky saturating overflow.
// Optional macro FACTORIAL_ENGINE_ABORT_EN adds an 'abort' input that ends
// CALC on the next edge with a saturated, overflow-flagged result.
// Ports:
//   clk, rst_n            clock (rising) and async active-low reset
//   in_valid/in_ready     request handshake; in_ready high only in IDLE
//   mode, n, k            operation and operands (k used by PERM only)
//   out_valid/out_ready   result handshake; result held until accepted
//   result, ovf           product (all-ones on overflow) and overflow flag
//   busy                  high while computing
//   abort                 (optional) cancel the running computation
module factorial_engine
  import factorial_engine_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  n,
  input  logic [IN_W-1:0]  k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             ovf,
  output logic             busy
`ifdef FACTORIAL_ENGINE_ABORT_EN
  ,
  input  logic             abort
`endif
);

  fe_state_t        state_q, state_d;
  fe_mode_t         mode_q, mode_d;
  logic [IN_W-1:0]  counter_q, counter_d;
  logic [IN_W-1:0]  steps_q, steps_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;

  logic [OUT_W-1:0] mul_prod;
  logic             mul_ovf;
  logic             abort_hit;
  logic [IN_W-1:0]  dec;

`ifdef FACTORIAL_ENGINE_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  fe_mul_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_mul (
    .acc     (result_q),
    .factor  (counter_q),
    .product (mul_prod),
    .ovf     (mul_ovf)
  );

  assign dec = (mode_q == DFACT) ? IN_W'(2) : IN_W'(1);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    counter_d = counter_q;
    steps_d   = steps_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d    = mode;
          counter_d = n;
          steps_d   = k;
          result_d  = OUT_W'(1);
          ovf_d     = 1'b0;
          state_d   = CALC;
        end
      end
      CALC: begin
        if (abort_hit) begin
          result_d = '1;
          ovf_d    = 1'b1;
          state_d  = DONE;
        end else if (mode_q == PERM) begin
          // counter and steps fall together, so steps > counter only when k > n.
          if (steps_q > counter_q) begin
            result_d = '0;
            ovf_d    = 1'b0;
            state_d  = DONE;
          end else if (steps_q != '0) begin
            result_d  = mul_prod;
            counter_d = counter_q - IN_W'(1);
            steps_d   = steps_q - IN_W'(1);
            if (mul_ovf) begin
              ovf_d   = 1'b1;
              state_d = DONE;
            end
          end else begin
            state_d = DONE;
          end
        end else begin
          // FACT, DFACT and RSVD; a step of 2 from 2 or 3 lands on 0 or 1, so no wrap.
          if (counter_q > IN_W'(1)) begin
            result_d  = mul_prod;
            counter_d = counter_q - dec;
            if (mul_ovf) begin
              ovf_d   = 1'b1;
              state_d = DONE;
            end
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mode_q    <= FACT;
      counter_q <= '0;
      steps_q   <= '0;
      result_q  <= OUT_W'(1);
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      counter_q <= counter_d;
      steps_q   <= steps_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_factorial_engine.sv
// tb_factorial_engine: directed and randomized checks of factorial_engine
// against an arithmetic reference model (OUT_W=32, IN_W=8).
module tb_factorial_engine;

  localparam longint MAXV = 64'h0000_0000_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [7:0]  n;
  logic [7:0]  k;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        busy;
`ifdef FACTORIAL_ENGINE_ABORT_EN
  logic        abort;
`endif

  int checks = 0;
  int errors = 0;

  factorial_engine #(
    .IN_W  (8),
    .OUT_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .n         (n),
    .k         (k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .busy      (busy)
`ifdef FACTORIAL_ENGINE_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the terms each mode multiplies.
  // lat = edges from acceptance to out_valid.
  function automatic void model(input int m, input int nn, input int kk,
                                output longint res, output bit ov, output int lat);
    longint p = 1;
    int mults = 0;
    ov = 0;
    if (m == 2) begin
      if (kk > nn) begin
        res = 0;
        lat = 1;
        return;
      end
      for (int i = 0; i < kk; i++) begin
        p = p * (nn - i);
        mults++;
        if (p > MAXV) begin
          ov = 1;
          break;
        end
      end
    end else begin
      int stp = (m == 1) ? 2 : 1;
      for (int i = nn; i > 1; i -= stp) begin
        p = p * i;
        mults++;
        if (p > MAXV) begin
          ov = 1;
          break;
        end
      end
    end
    lat = ov ? mults : mults + 1;
    res = ov ? MAXV : p;
  endfunction

  task automatic run(input int m, input int nn, input int kk, input int hold, input bit early,
                     output logic [31:0] got);
    longint er;
    bit     eo;
    int     el;
    int     lat;
    model(m, nn, kk, er, eo, el);
    @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    mode      = m[1:0];
    n         = nn[7:0];
    k         = kk[7:0];
    out_ready = early;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n        = 8'($urandom);
    k        = 8'($urandom);
    mode     = 2'($urandom);
    lat      = 0;
    while (!out_valid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(el));
    chk("result", 64'(result), er);
    chk("ovf", 64'(ovf), 64'(eo));
    chk("busy_done", 64'(busy), 64'd0);
    chk("in_ready_done", 64'(in_ready), 64'd0);
    got = result;
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        n        = 8'($urandom);
        @(posedge clk);
        #1;
        chk("hold_result", 64'(result), er);
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_in_ready", 64'(in_ready), 64'd0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("released_valid", 64'(out_valid), 64'd0);
    chk("released_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] got;
    int          m;
    int          nn;
    int          kk;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    mode      = 2'd0;
    n         = 8'd0;
    k         = 8'd0;
    out_ready = 1'b0;
`ifdef FACTORIAL_ENGINE_ABORT_EN
    abort     = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd1);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // out_ready while idle is ignored
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_oready_valid", 64'(out_valid), 64'd0);
    chk("idle_oready_ready", 64'(in_ready), 64'd1);

    run(0, 5, 0, 0, 1'b1, got);
    chk("fact5", 64'(got), 64'd120);
    run(0, 12, 0, 0, 1'b0, got);
    chk("fact12", 64'(got), 64'd479001600);
    run(0, 13, 0, 1, 1'b0, got);
    chk("fact13", 64'(got), 64'hFFFF_FFFF);
    run(1, 7, 0, 0, 1'b0, got);
    chk("dfact7", 64'(got), 64'd105);
    run(1, 8, 0, 0, 1'b0, got);
    chk("dfact8", 64'(got), 64'd384);
    run(2, 10, 3, 0, 1'b0, got);
    chk("perm10_3", 64'(got), 64'd720);
    run(2, 3, 5, 0, 1'b0, got);
    chk("perm3_5", 64'(got), 64'd0);
    run(0, 0, 0, 0, 1'b0, got);
    chk("fact0", 64'(got), 64'd1);
    run(1, 0, 0, 0, 1'b0, got);
    chk("dfact0", 64'(got), 64'd1);
    run(2, 9, 0, 0, 1'b0, got);
    chk("perm9_0", 64'(got), 64'd1);
    run(3, 4, 0, 0, 1'b0, got);
    chk("rsvd4", 64'(got), 64'd24);

    // Backpressure with ignored in_valid pulses
    run(0, 4, 0, 10, 1'b0, got);
    chk("bp_fact4", 64'(got), 64'd24);

    // Async reset mid-CALC
    @(negedge clk);
    in_valid = 1'b1;
    mode     = 2'd0;
    n        = 8'd10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("midcalc_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd1);
    chk("arst_ovf", 64'(ovf), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 3, 0, 0, 1'b0, got);
    chk("after_rst_fact3", 64'(got), 64'd6);

    // Randomized requests against the model
    for (int t = 0; t < 30; t++) begin
      m = $urandom_range(0, 3);
      kk = 0;
      if (m == 1) nn = $urandom_range(0, 40);
      else if (m == 2) begin
        nn = $urandom_range(0, 60);
        kk = $urandom_range(0, 12);
      end else nn = $urandom_range(0, 15);
      run(m, nn, kk, $urandom_range(0, 3), 1'($urandom), got);
    end

`ifdef FACTORIAL_ENGINE_ABORT_EN
    // abort in IDLE has no effect
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_idle", 64'(in_ready), 64'd1);
    // abort on the 3rd CALC cycle of FACT 10
    @(negedge clk);
    in_valid = 1'b1;
    mode     = 2'd0;
    n        = 8'd10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd1);
    chk("abort_result", 64'(result), 64'hFFFF_FFFF);
    chk("abort_ovf", 64'(ovf), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("abort_released", 64'(in_ready), 64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
